// File: rtl/tlb_miss_walk_arbiter_pkg.sv
// Shared types and defaults for the ITLB/DTLB walker arbiter.
package tlb_miss_walk_arbiter_pkg;

   localparam int unsigned DEFAULT_VLEN         = 32;
   localparam int unsigned DEFAULT_STARVE_LIMIT = 4;
   localparam int unsigned DEFAULT_CNT_W        = 4;

   typedef enum logic {
      OWNER_DTLB = 1'b0,
      OWNER_ITLB = 1'b1
   } walk_owner_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } arb_state_e;

endpackage

// File: rtl/tlb_miss_walk_arbiter_prio_sel.sv
// Winner select between ITLB and DTLB misses with a bounded-wait counter
// that forces an ITLB win after too many consecutive DTLB wins.
module tlb_walk_prio_sel
   import tlb_miss_walk_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
   parameter int unsigned CNT_W        = DEFAULT_CNT_W
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic arb_en_i,
   input  logic itlb_req_i,
   input  logic dtlb_req_i,
   output logic itlb_win_o,
   output logic dtlb_win_o
);

   logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
   logic             starved;

   assign starved = (starve_cnt_q >= CNT_W'(STARVE_LIMIT));

   // DTLB wins by default; ITLB wins alone or once it has waited long enough
   always_comb begin
      itlb_win_o = 1'b0;
      dtlb_win_o = 1'b0;
      if (arb_en_i) begin
         if (itlb_req_i && (!dtlb_req_i || starved)) begin
            itlb_win_o = 1'b1;
         end else if (dtlb_req_i) begin
            dtlb_win_o = 1'b1;
         end
      end
   end

   // Count DTLB wins that bypassed a waiting ITLB; saturate, clear on ITLB win
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (itlb_win_o) begin
         starve_cnt_d = '0;
      end else if (dtlb_win_o && itlb_req_i && (starve_cnt_q != '1)) begin
         starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end
   end

   // Counter register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end

endmodule

// File: rtl/tlb_miss_walk_arbiter.sv
// Shares one Sv32 page-table walker between the ITLB and DTLB miss paths:
// grants one miss at a time, drives the walker handshake, routes the
// completion back to the owner and swallows walks killed by a flush.
module tlb_miss_walk_arbiter
   import tlb_miss_walk_arbiter_pkg::*;
#(
   parameter int unsigned VLEN         = DEFAULT_VLEN,
   parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
   parameter int unsigned CNT_W        = DEFAULT_CNT_W
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            flush_i,
   input  logic            itlb_req_i,
   input  logic [VLEN-1:0] itlb_vaddr_i,
   output logic            itlb_gnt_o,
   output logic            itlb_done_o,
   output logic            itlb_err_o,
   input  logic            dtlb_req_i,
   input  logic [VLEN-1:0] dtlb_vaddr_i,
   input  logic            dtlb_is_store_i,
   output logic            dtlb_gnt_o,
   output logic            dtlb_done_o,
   output logic            dtlb_err_o,
   output logic            ptw_req_o,
   output logic [VLEN-1:0] ptw_vaddr_o,
   output logic            ptw_is_instr_o,
   output logic            ptw_is_store_o,
   input  logic            ptw_ready_i,
   input  logic            ptw_done_i,
   input  logic            ptw_err_i
);

   arb_state_e      state_q, state_d;
   walk_owner_e     owner_q, owner_d;
   logic [VLEN-1:0] vaddr_q, vaddr_d;
   logic            store_q, store_d;
   logic            drop_q,  drop_d;
   logic            arb_en;
   logic            itlb_win, dtlb_win;

   assign arb_en = (state_q == IDLE) && !flush_i;

   tlb_walk_prio_sel #(
      .STARVE_LIMIT (STARVE_LIMIT),
      .CNT_W        (CNT_W)
   ) u_prio_sel (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .arb_en_i   (arb_en),
      .itlb_req_i (itlb_req_i),
      .dtlb_req_i (dtlb_req_i),
      .itlb_win_o (itlb_win),
      .dtlb_win_o (dtlb_win)
   );

   assign ptw_vaddr_o    = vaddr_q;
   assign ptw_is_instr_o = (owner_q == OWNER_ITLB);
   assign ptw_is_store_o = store_q;

   // Next-state, grant, walker request and completion routing
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      vaddr_d     = vaddr_q;
      store_d     = store_q;
      drop_d      = drop_q;
      itlb_gnt_o  = 1'b0;
      dtlb_gnt_o  = 1'b0;
      itlb_done_o = 1'b0;
      itlb_err_o  = 1'b0;
      dtlb_done_o = 1'b0;
      dtlb_err_o  = 1'b0;
      ptw_req_o   = 1'b0;
      case (state_q)
         IDLE: begin
            if (itlb_win) begin
               itlb_gnt_o = 1'b1;
               owner_d    = OWNER_ITLB;
               vaddr_d    = itlb_vaddr_i;
               store_d    = 1'b0;
               state_d    = ISSUE;
            end else if (dtlb_win) begin
               dtlb_gnt_o = 1'b1;
               owner_d    = OWNER_DTLB;
               vaddr_d    = dtlb_vaddr_i;
               store_d    = dtlb_is_store_i;
               state_d    = ISSUE;
            end
         end
         ISSUE: begin
            // A flush withdraws the request even if the walker accepts it now
            if (flush_i) begin
               state_d = IDLE;
            end else begin
               ptw_req_o = 1'b1;
               if (ptw_ready_i) begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (ptw_done_i) begin
               state_d = IDLE;
               drop_d  = 1'b0;
               if (!drop_q && !flush_i) begin
                  if (owner_q == OWNER_ITLB) begin
                     itlb_done_o = !ptw_err_i;
                     itlb_err_o  = ptw_err_i;
                  end else begin
                     dtlb_done_o = !ptw_err_i;
                     dtlb_err_o  = ptw_err_i;
                  end
               end
            end else if (flush_i) begin
               drop_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and latched request registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         owner_q <= OWNER_DTLB;
         vaddr_q <= '0;
         store_q <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         vaddr_q <= vaddr_d;
         store_q <= store_d;
         drop_q  <= drop_d;
      end
   end

endmodule

// File: tb/tb_tlb_miss_walk_arbiter.sv
// Bench for tlb_miss_walk_arbiter: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_tlb_miss_walk_arbiter;

   localparam int unsigned VLEN  = 32;
   localparam int unsigned LIMIT = 4;
   localparam int unsigned CNT_W = 4;
   localparam int          CNT_MAX = (1 << CNT_W) - 1;

   logic            clk_i = 1'b0;
   logic            rst_ni;
   logic            flush_i;
   logic            itlb_req_i;
   logic [VLEN-1:0] itlb_vaddr_i;
   logic            itlb_gnt_o, itlb_done_o, itlb_err_o;
   logic            dtlb_req_i;
   logic [VLEN-1:0] dtlb_vaddr_i;
   logic            dtlb_is_store_i;
   logic            dtlb_gnt_o, dtlb_done_o, dtlb_err_o;
   logic            ptw_req_o;
   logic [VLEN-1:0] ptw_vaddr_o;
   logic            ptw_is_instr_o, ptw_is_store_o;
   logic            ptw_ready_i, ptw_done_i, ptw_err_i;

   tlb_miss_walk_arbiter #(
      .VLEN(VLEN), .STARVE_LIMIT(LIMIT), .CNT_W(CNT_W)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
      .itlb_req_i(itlb_req_i), .itlb_vaddr_i(itlb_vaddr_i),
      .itlb_gnt_o(itlb_gnt_o), .itlb_done_o(itlb_done_o), .itlb_err_o(itlb_err_o),
      .dtlb_req_i(dtlb_req_i), .dtlb_vaddr_i(dtlb_vaddr_i),
      .dtlb_is_store_i(dtlb_is_store_i),
      .dtlb_gnt_o(dtlb_gnt_o), .dtlb_done_o(dtlb_done_o), .dtlb_err_o(dtlb_err_o),
      .ptw_req_o(ptw_req_o), .ptw_vaddr_o(ptw_vaddr_o),
      .ptw_is_instr_o(ptw_is_instr_o), .ptw_is_store_o(ptw_is_store_o),
      .ptw_ready_i(ptw_ready_i), .ptw_done_i(ptw_done_i), .ptw_err_i(ptw_err_i)
   );

   always #5 clk_i = ~clk_i;

   // in  bits: {itlb_req, dtlb_req, dtlb_is_store, flush, ready, done, err}
   // exp bits: {itlb_gnt, dtlb_gnt, ptw_req, itlb_done, itlb_err,
   //            dtlb_done, dtlb_err, ptw_is_instr, ptw_is_store}
   typedef struct {
      logic [6:0]  in;
      logic [31:0] iv;
      logic [31:0] dv;
      logic [8:0]  exp;
      logic [31:0] ev;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [1:0] g;

   function automatic vec_t mkv(input logic [6:0] in, input logic [31:0] iv,
                                input logic [31:0] dv, input logic [8:0] exp,
                                input logic [31:0] ev);
      vec_t v;
      v.in = in; v.iv = iv; v.dv = dv; v.exp = exp; v.ev = ev;
      return v;
   endfunction

   function automatic logic [63:0] obs();
      return 64'({itlb_gnt_o, dtlb_gnt_o, ptw_req_o, itlb_done_o, itlb_err_o,
                  dtlb_done_o, dtlb_err_o, ptw_is_instr_o, ptw_is_store_o,
                  ptw_vaddr_o});
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [6:0] in, input logic [31:0] iv, input logic [31:0] dv);
      {itlb_req_i, dtlb_req_i, dtlb_is_store_i, flush_i,
       ptw_ready_i, ptw_done_i, ptw_err_i} = in;
      itlb_vaddr_i = iv;
      dtlb_vaddr_i = dv;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // One cycle: drive, compare all outputs at the falling edge, advance
   task automatic step(input string name, input logic [6:0] in, input logic [31:0] iv,
                       input logic [31:0] dv, input logic [8:0] e, input logic [31:0] ev);
      drive(in, iv, dv);
      @(negedge clk_i);
      check(name, obs(), 64'({e, ev}));
      tick();
   endtask

   // Full walk: request pattern, report who was granted, then ready/wait/done
   task automatic walk_cycle(input logic iq, input logic dq, output logic [1:0] gr);
      drive({iq, dq, 5'b00000}, 32'h1111_1000, 32'h2222_2000);
      @(negedge clk_i);
      gr = {itlb_gnt_o, dtlb_gnt_o};
      tick();
      if (gr[1]) itlb_req_i = 1'b0;
      if (gr[0]) dtlb_req_i = 1'b0;
      ptw_ready_i = 1'b1;
      tick();
      ptw_ready_i = 1'b0;
      tick();
      ptw_done_i = 1'b1;
      tick();
      ptw_done_i = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Behavioural model state for the random phase
   bit          m_busy, m_sent, m_own_i, m_store, m_drop;
   logic [31:0] m_addr;
   int          m_dwins;

   initial begin
      rst_ni = 1'b0;
      drive(7'b0, 32'h0, 32'h0);
      @(negedge clk_i);
      check("reset_outputs", obs(), 64'h0);
      tick();
      rst_ni = 1'b1;

      // ITLB alone: grant@0, req@1-2, done@6
      vecs.push_back(mkv(7'b1000000, 32'h8000_1000, 32'h0, 9'b100000000, 32'h0));
      vecs.push_back(mkv(7'b0000000, 32'h8000_1000, 32'h0, 9'b001000010, 32'h8000_1000));
      vecs.push_back(mkv(7'b0000100, 32'h8000_1000, 32'h0, 9'b001000010, 32'h8000_1000));
      vecs.push_back(mkv(7'b0000000, 32'h8000_1000, 32'h0, 9'b000000010, 32'h8000_1000));
      vecs.push_back(mkv(7'b0000000, 32'h8000_1000, 32'h0, 9'b000000010, 32'h8000_1000));
      vecs.push_back(mkv(7'b0000000, 32'h8000_1000, 32'h0, 9'b000000010, 32'h8000_1000));
      vecs.push_back(mkv(7'b0000010, 32'h8000_1000, 32'h0, 9'b000100010, 32'h8000_1000));
      vecs.push_back(mkv(7'b0000000, 32'h8000_1000, 32'h0, 9'b000000010, 32'h8000_1000));
      // DTLB store miss that faults
      vecs.push_back(mkv(7'b0110000, 32'h0, 32'h0000_2FFC, 9'b010000010, 32'h8000_1000));
      vecs.push_back(mkv(7'b0000100, 32'h0, 32'h0000_2FFC, 9'b001000001, 32'h0000_2FFC));
      vecs.push_back(mkv(7'b0000000, 32'h0, 32'h0000_2FFC, 9'b000000001, 32'h0000_2FFC));
      vecs.push_back(mkv(7'b0000011, 32'h0, 32'h0000_2FFC, 9'b000000101, 32'h0000_2FFC));
      vecs.push_back(mkv(7'b0000000, 32'h0, 32'h0000_2FFC, 9'b000000001, 32'h0000_2FFC));
      // Flush together with ready in ISSUE, pending ITLB granted next cycle
      vecs.push_back(mkv(7'b1100000, 32'h0040_0000, 32'h1234_5678, 9'b010000001, 32'h0000_2FFC));
      vecs.push_back(mkv(7'b1001100, 32'h0040_0000, 32'h1234_5678, 9'b000000000, 32'h1234_5678));
      vecs.push_back(mkv(7'b1000000, 32'h0040_0000, 32'h1234_5678, 9'b100000000, 32'h1234_5678));
      vecs.push_back(mkv(7'b0000100, 32'h0040_0000, 32'h1234_5678, 9'b001000010, 32'h0040_0000));
      vecs.push_back(mkv(7'b0000010, 32'h0040_0000, 32'h1234_5678, 9'b000100010, 32'h0040_0000));
      vecs.push_back(mkv(7'b0000000, 32'h0040_0000, 32'h1234_5678, 9'b000000010, 32'h0040_0000));

      foreach (vecs[k]) begin
         step($sformatf("vec[%0d]", k), vecs[k].in, vecs[k].iv, vecs[k].dv,
              vecs[k].exp, vecs[k].ev);
      end

      // Both requesting every grant: four DTLB wins, then the ITLB
      for (int k = 0; k < 10; k++) begin
         walk_cycle(1'b1, 1'b1, g);
         check($sformatf("starve_order[%0d]", k), 64'(g),
               (k == 4 || k == 9) ? 64'h2 : 64'h1);
      end

      // Flush in WAIT: completion swallowed, next grant right after ptw_done
      step("fw_gnt",    7'b0100000, 32'h0, 32'h0000_5000, 9'b010000010, 32'h1111_1000);
      step("fw_issue",  7'b0000100, 32'h0, 32'h0000_5000, 9'b001000000, 32'h0000_5000);
      step("fw_flush",  7'b0001000, 32'h0, 32'h0000_5000, 9'b000000000, 32'h0000_5000);
      step("fw_wait1",  7'b1000000, 32'h0000_7000, 32'h0, 9'b000000000, 32'h0000_5000);
      step("fw_wait2",  7'b1000000, 32'h0000_7000, 32'h0, 9'b000000000, 32'h0000_5000);
      step("fw_done",   7'b1000011, 32'h0000_7000, 32'h0, 9'b000000000, 32'h0000_5000);
      step("fw_regnt",  7'b1000000, 32'h0000_7000, 32'h0, 9'b100000000, 32'h0000_5000);
      step("fw_issue2", 7'b0000100, 32'h0000_7000, 32'h0, 9'b001000010, 32'h0000_7000);
      step("fw_done2",  7'b0000010, 32'h0000_7000, 32'h0, 9'b000100010, 32'h0000_7000);
      step("fw_idle",   7'b0000000, 32'h0000_7000, 32'h0, 9'b000000010, 32'h0000_7000);

      // Reset mid-WAIT after the starvation counter has advanced
      walk_cycle(1'b1, 1'b1, g);
      check("pre_rst_gnt0", 64'(g), 64'h1);
      walk_cycle(1'b1, 1'b1, g);
      check("pre_rst_gnt1", 64'(g), 64'h1);
      drive(7'b1100000, 32'h1111_1000, 32'h2222_2000);
      @(negedge clk_i);
      check("pre_rst_gnt2", 64'({itlb_gnt_o, dtlb_gnt_o}), 64'h1);
      tick();
      drive(7'b1000100, 32'h1111_1000, 32'h2222_2000);
      tick();
      drive(7'b0, 32'h0, 32'h0);
      rst_ni = 1'b0;
      #1;
      check("rst_mid_wait", obs(), 64'h0);
      tick();
      tick();
      rst_ni = 1'b1;
      step("late_done", 7'b0000010, 32'h0, 32'h0, 9'b0, 32'h0);
      step("post_late", 7'b0000000, 32'h0, 32'h0, 9'b0, 32'h0);
      for (int k = 0; k < 5; k++) begin
         walk_cycle(1'b1, 1'b1, g);
         check($sformatf("post_rst_order[%0d]", k), 64'(g), (k == 4) ? 64'h2 : 64'h1);
      end

      // Randomized traffic against the behavioural model
      drive(7'b0, 32'h0, 32'h0);
      rst_ni = 1'b0;
      tick();
      tick();
      rst_ni = 1'b1;
      m_busy = 0; m_sent = 0; m_own_i = 0; m_store = 0; m_drop = 0;
      m_addr = '0; m_dwins = 0;
      for (int c = 0; c < 3000; c++) begin
         logic [8:0] e;
         logic       gi, gd;
         if (!itlb_req_i) begin
            itlb_req_i   = ($urandom_range(0, 3) == 0);
            itlb_vaddr_i = $urandom;
         end else if ($urandom_range(0, 31) == 0) begin
            itlb_req_i = 1'b0;
         end
         if (!dtlb_req_i) begin
            dtlb_req_i      = ($urandom_range(0, 2) == 0);
            dtlb_vaddr_i    = $urandom;
            dtlb_is_store_i = 1'($urandom_range(0, 1));
         end else if ($urandom_range(0, 31) == 0) begin
            dtlb_req_i = 1'b0;
         end
         flush_i     = ($urandom_range(0, 15) == 0);
         ptw_ready_i = 1'($urandom_range(0, 1));
         ptw_done_i  = ($urandom_range(0, 3) == 0);
         ptw_err_i   = 1'($urandom_range(0, 1));

         e  = {7'b0, m_own_i, m_store};
         gi = 1'b0;
         gd = 1'b0;
         if (!m_busy) begin
            if (!flush_i && (itlb_req_i || dtlb_req_i)) begin
               if (itlb_req_i && (!dtlb_req_i || m_dwins >= int'(LIMIT))) gi = 1'b1;
               else gd = 1'b1;
            end
         end else if (!m_sent) begin
            e[6] = !flush_i;
         end else if (ptw_done_i && !m_drop && !flush_i) begin
            if (m_own_i) begin e[5] = !ptw_err_i; e[4] = ptw_err_i; end
            else         begin e[3] = !ptw_err_i; e[2] = ptw_err_i; end
         end
         e[8] = gi;
         e[7] = gd;
         @(negedge clk_i);
         check($sformatf("rand[%0d]", c), obs(), 64'({e, m_addr}));

         if (!m_busy) begin
            if (gi) begin
               m_busy = 1; m_sent = 0; m_own_i = 1; m_addr = itlb_vaddr_i;
               m_store = 0; m_dwins = 0;
            end else if (gd) begin
               m_busy = 1; m_sent = 0; m_own_i = 0; m_addr = dtlb_vaddr_i;
               m_store = dtlb_is_store_i;
               if (itlb_req_i && m_dwins < CNT_MAX) m_dwins++;
            end
         end else if (!m_sent) begin
            if (flush_i) m_busy = 0;
            else if (ptw_ready_i) m_sent = 1;
         end else begin
            if (ptw_done_i) begin m_busy = 0; m_drop = 0; end
            else if (flush_i) m_drop = 1;
         end
         tick();
         if (gi) itlb_req_i = 1'b0;
         if (gd) dtlb_req_i = 1'b0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
